// File: rtl/neosd_card_cmd_fsm.sv
// neosd_card_cmd_fsm
// Card-side SD CMD line engine. It receives 48-bit host commands, checks
// framing and CRC7, and presents them to the card logic. It then sends either
// a 48-bit short response (R1/R3/R6/R7 style, CRC7 appended) or a 136-bit
// long response (R2 style, CRC already inside the supplied image).
//
// Ports
//   clk_i, rstn_i       system clock, asynchronous active-low reset
//   clkstrb_i           one-clk strobe per SD clock; all line activity uses it
//   fsm_rst_i           synchronous engine reset (highest priority)
//   sd_cmd_i            CMD line input
//   sd_cmd_o, sd_cmd_oe CMD line drive value / output enable
//   cmd_valid_o         a well-framed command is waiting for a response
//   cmd_idx_o/arg_o     index/argument of the last good command
//   cmd_crc_ok_o        CRC7 of the last good command matched
//   cmd_err_o           one-clk pulse on a framing error
//   resp_start_i        response request (latched on any clk while waiting)
//   resp_mode_i         0/3 none, 1 short, 2 long (sampled with resp_start_i)
//   resp_idx_i          short response index field
//   resp_data_i         short: [31:0] payload, long: 128-bit CID/CSD image
//   status_idle_o       engine idle
//   status_busy_o       engine transmitting
//   resp_done_o         one-clk pulse after the response end bit
//   timeout_o           one-clk pulse when no response request arrives in time
module neosd_card_cmd_fsm #(
  parameter int NCR_MIN = 2,
  parameter int NCR_MAX = 64
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clkstrb_i,
  input  logic         fsm_rst_i,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_idx_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_crc_ok_o,
  output logic         cmd_err_o,
  input  logic         resp_start_i,
  input  logic [1:0]   resp_mode_i,
  input  logic [5:0]   resp_idx_i,
  input  logic [127:0] resp_data_i,
  output logic         status_idle_o,
  output logic         status_busy_o,
  output logic         resp_done_o,
  output logic         timeout_o
);

  localparam int NCR_W = $clog2(NCR_MAX + 1) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_WAIT, ST_SEND} state_t;

  state_t             state_q;
  logic [5:0]         bit_cnt_q;
  logic [46:0]        rx_q;        // bits received so far, start bit at the top
  logic [NCR_W-1:0]   ncr_cnt_q;
  logic [135:0]       tx_q;        // remaining response bits, MSB goes next
  logic [7:0]         tx_left_q;
  logic               pending_q;
  logic [1:0]         mode_q;

  // Serial CRC7 (x^7 + x^3 + 1, init 0) over 40 bits, MSB first.
  function automatic logic [6:0] crc7_40(input logic [39:0] bits);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 39; i >= 0; i--) begin
      fb  = bits[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  // The end bit is still on the line during the evaluating strobe.
  logic [47:0]      rx_frame_d;
  logic [6:0]       rx_crc_d;
  logic             rx_frame_ok_d;
  logic [NCR_W-1:0] ncr_cnt_d;
  logic             go_pending_d;
  logic [1:0]       go_mode_d;
  logic             go_send_d;
  logic [39:0]      short_head_d;
  logic [135:0]     tx_frame_d;

  assign rx_frame_d    = {rx_q, sd_cmd_i};
  assign rx_crc_d      = crc7_40(rx_frame_d[47:8]);
  assign rx_frame_ok_d = rx_frame_d[46] & rx_frame_d[0];
  assign ncr_cnt_d     = ncr_cnt_q + NCR_W'(1);

  // A request arriving on the strobe clock itself is acted on immediately.
  assign go_pending_d  = pending_q | resp_start_i;
  assign go_mode_d     = pending_q ? mode_q : resp_mode_i;
  assign go_send_d     = (go_mode_d == 2'd1) || (go_mode_d == 2'd2);

  assign short_head_d  = {2'b00, resp_idx_i, resp_data_i[31:0]};
  assign tx_frame_d    = (go_mode_d == 2'd2)
                         ? {2'b00, 6'h3f, resp_data_i[127:1], 1'b1}
                         : {short_head_d, crc7_40(short_head_d), 1'b1, 88'd0};

  assign status_idle_o = (state_q == ST_IDLE);
  assign status_busy_o = (state_q == ST_SEND);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      ncr_cnt_q    <= '0;
      tx_q         <= '0;
      tx_left_q    <= '0;
      pending_q    <= 1'b0;
      mode_q       <= '0;
      sd_cmd_o     <= 1'b1;
      sd_cmd_oe    <= 1'b0;
      cmd_valid_o  <= 1'b0;
      cmd_idx_o    <= '0;
      cmd_arg_o    <= '0;
      cmd_crc_ok_o <= 1'b0;
      cmd_err_o    <= 1'b0;
      resp_done_o  <= 1'b0;
      timeout_o    <= 1'b0;
    end else if (fsm_rst_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      ncr_cnt_q    <= '0;
      tx_q         <= '0;
      tx_left_q    <= '0;
      pending_q    <= 1'b0;
      mode_q       <= '0;
      sd_cmd_o     <= 1'b1;
      sd_cmd_oe    <= 1'b0;
      cmd_valid_o  <= 1'b0;
      cmd_idx_o    <= '0;
      cmd_arg_o    <= '0;
      cmd_crc_ok_o <= 1'b0;
      cmd_err_o    <= 1'b0;
      resp_done_o  <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      cmd_err_o   <= 1'b0;
      resp_done_o <= 1'b0;
      timeout_o   <= 1'b0;

      // Request latch works on every clk, not only on strobes.
      if ((state_q == ST_WAIT) && resp_start_i && !pending_q) begin
        pending_q <= 1'b1;
        mode_q    <= resp_mode_i;
      end

      if (clkstrb_i) begin
        case (state_q)
          ST_IDLE: begin
            if (!sd_cmd_i) begin
              state_q   <= ST_RECV;
              bit_cnt_q <= 6'd1;
              rx_q      <= '0;
            end
          end

          ST_RECV: begin
            if (bit_cnt_q == 6'd47) begin
              if (rx_frame_ok_d) begin
                state_q      <= ST_WAIT;
                cmd_valid_o  <= 1'b1;
                cmd_idx_o    <= rx_frame_d[45:40];
                cmd_arg_o    <= rx_frame_d[39:8];
                cmd_crc_ok_o <= (rx_crc_d == rx_frame_d[7:1]);
                ncr_cnt_q    <= '0;
                pending_q    <= 1'b0;
              end else begin
                state_q   <= ST_IDLE;
                cmd_err_o <= 1'b1;
              end
            end else begin
              rx_q      <= {rx_q[45:0], sd_cmd_i};
              bit_cnt_q <= bit_cnt_q + 6'd1;
            end
          end

          ST_WAIT: begin
            ncr_cnt_q <= ncr_cnt_d;
            if (go_pending_d) begin
              if (!go_send_d) begin
                state_q     <= ST_IDLE;
                cmd_valid_o <= 1'b0;
                pending_q   <= 1'b0;
              end else if (ncr_cnt_d >= NCR_W'(NCR_MIN)) begin
                // Start bit goes out on this strobe; the rest follows.
                state_q     <= ST_SEND;
                cmd_valid_o <= 1'b0;
                pending_q   <= 1'b0;
                sd_cmd_oe   <= 1'b1;
                sd_cmd_o    <= tx_frame_d[135];
                tx_q        <= {tx_frame_d[134:0], 1'b0};
                tx_left_q   <= (go_mode_d == 2'd2) ? 8'd135 : 8'd47;
              end
            end else if (ncr_cnt_d == NCR_W'(NCR_MAX)) begin
              state_q     <= ST_IDLE;
              cmd_valid_o <= 1'b0;
              timeout_o   <= 1'b1;
            end
          end

          ST_SEND: begin
            if (tx_left_q != 8'd0) begin
              sd_cmd_o  <= tx_q[135];
              tx_q      <= {tx_q[134:0], 1'b0};
              tx_left_q <= tx_left_q - 8'd1;
            end else begin
              state_q     <= ST_IDLE;
              sd_cmd_oe   <= 1'b0;
              sd_cmd_o    <= 1'b1;
              resp_done_o <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/neosd_card_cmd_fsm.md
NEOSD_CARD_CMD_FSM -- requirements
Module: neosd_card_cmd_fsm

Card-side (responder) command-line engine for SD CMD. Receives 48-bit host commands, checks framing and CRC7, presents them to the card logic, and transmits R1/R3/R6/R7-style short or R2-style long responses.

Interface
REQ-001 Parameter NCR_MIN, default 2: minimum strobes from command end bit to response start bit.
REQ-002 Parameter NCR_MAX, default 64: strobes after command end bit before an unanswered command times out.
REQ-003 clk_i  in  1  system clock; single clock domain.
REQ-004 rstn_i  in  1  reset; asynchronous, active-low.
REQ-005 clkstrb_i  in  1  one-clk_i strobe per SD clock period; all line sampling, driving and counting occur only on it.
REQ-006 fsm_rst_i  in  1  synchronous FSM reset.
REQ-007 sd_cmd_i  in  1  CMD line input.
REQ-008 sd_cmd_o  out  1  CMD line drive value.
REQ-009 sd_cmd_oe  out  1  CMD line output enable.
REQ-010 cmd_valid_o  out  1  high while a received, well-framed command awaits response.
REQ-011 cmd_idx_o  out  6  received command index.
REQ-012 cmd_arg_o  out  32  received argument.
REQ-013 cmd_crc_ok_o  out  1  received CRC7 matched; valid with cmd_valid_o.
REQ-014 cmd_err_o  out  1  one-clk pulse on framing error.
REQ-015 resp_start_i  in  1  request response for current command; latched on any clk_i while cmd_valid_o.
REQ-016 resp_mode_i  in  2  0 NONE, 1 SHORT, 2 LONG, 3 treated as NONE; sampled with resp_start_i.
REQ-017 resp_idx_i  in  6  short-response index field.
REQ-018 resp_data_i  in  128  short: [31:0] payload; long: full 128-bit CID/CSD image incl. internal CRC.
REQ-019 status_idle_o  out  1  FSM in IDLE.
REQ-020 status_busy_o  out  1  FSM in SEND.
REQ-021 resp_done_o  out  1  one-clk pulse when response end bit completes.
REQ-022 timeout_o  out  1  one-clk pulse on NCR_MAX expiry.

Function
REQ-023 States IDLE, RECV, WAIT, SEND. Transitions occur only on clkstrb_i, except latching per REQ-015 and fsm_rst_i.
REQ-024 IDLE: sampled 0 on a strobe counts as start bit 0 -> RECV, bit_cnt=1. Sampled 1 -> stay.
REQ-025 RECV: shift one bit per strobe MSB first. The strobe sampling bit 47, the end bit, evaluates the frame.
REQ-026 Frame check: transmission bit (bit 46) must be 1 and end bit must be 1. On failure, cmd_err_o pulses and the FSM returns to IDLE with cmd_valid_o low.
REQ-027 CRC7: polynomial x^7+x^3+1, init 0, over bits 47..8. cmd_crc_ok_o=1 iff the result equals bits 7..1. A CRC mismatch does not block cmd_valid_o.
REQ-028 Good frame -> WAIT: cmd_valid_o, cmd_idx_o, cmd_arg_o and cmd_crc_ok_o are registered on the end-bit strobe; ncr_cnt=0.
REQ-029 cmd_idx_o, cmd_arg_o and cmd_crc_ok_o hold until the next good frame.
REQ-030 WAIT: ncr_cnt increments on each strobe.
REQ-031 WAIT, start pending and mode NONE: on the next strobe, go to IDLE and drop cmd_valid_o; no resp_done_o.
REQ-032 WAIT, start pending, mode SHORT/LONG, ncr_cnt >= NCR_MIN: on that strobe, load the frame, drive the start bit (oe=1, o=0), go to SEND, drop cmd_valid_o.
REQ-033 WAIT, ncr_cnt reaches NCR_MAX with no start pending: timeout_o pulses, the FSM goes to IDLE, cmd_valid_o drops.
REQ-034 resp_start_i asserted in SEND or IDLE is ignored; the pending flag clears on leaving WAIT.
REQ-035 Short frame (48 bits): 0, 0, resp_idx_i, resp_data_i[31:0], CRC7 computed over the preceding 40 bits, 1.
REQ-036 Long frame (136 bits): 0, 0, 6'b111111, resp_data_i[127:1], 1; no CRC is computed.
REQ-037 Response inputs are captured at the start-bit strobe; later changes have no effect.
REQ-038 SEND: one bit per strobe, MSB first. On the strobe after the last bit: oe=0, o=1, resp_done_o pulses, IDLE. The start bit is detected afresh from that strobe on.
REQ-039 sd_cmd_i is ignored outside IDLE and RECV.
REQ-040 fsm_rst_i asserted on any clk_i forces the reset state on the next edge and overrides all else; a frame in progress is abandoned without a pulse.

Reset
REQ-041 On rstn_i low, asynchronously: state IDLE, all counters 0, sd_cmd_oe=0, sd_cmd_o=1, all pulse and status outputs 0 except status_idle_o=1, cmd_idx_o/cmd_arg_o/cmd_crc_ok_o=0, start pending cleared.

Verification
REQ-042 Drive CMD0 frame 0x40_0000_0000_95 -> cmd_valid_o=1, idx 0, arg 0, crc_ok 1. Then resp_start_i with NONE -> IDLE, no oe.
REQ-043 Drive CMD8 with arg 0x000001AA but CRC byte 0x00 -> cmd_valid_o=1, crc_ok 0. Then SHORT, idx 8, data 0x1AA -> oe rises exactly 2 strobes after the end bit; 48 bits match the bench CRC7 model; resp_done_o pulses.
REQ-044 CMD2 frame, then LONG with resp_data_i=0xDEADBEEF_01234567_89ABCDEF_00112232 -> 136 bits 0,0,111111,data[127:1],1; status_busy_o high throughout.
REQ-045 Good frame with no resp_start_i -> timeout_o pulses on strobe 64 after the end bit; cmd_valid_o drops.
REQ-046 Frame with bit 46=0 -> cmd_err_o pulse, no cmd_valid_o. Second, fsm_rst_i mid-SEND -> next clk oe=0, IDLE, no resp_done_o.
REQ-047 Strobe gaps of 1, 3 and 7 clk_i -> identical bit sequences, and resp_start_i held one clk_i between strobes is still honoured.
